oam_dma_controller: RTL and testbench

OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

---
 rtl/gb_mem_pkg.sv | 17 +
 rtl/oam_dma_controller.sv | 119 +++++++++++
 tb/tb_oam_dma_controller.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and the OAM DMA state encoding.
package gb_mem_pkg;

   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [15:0] HRAM_LO      = 16'hFF80;
   localparam logic [15:0] HRAM_HI      = 16'hFFFE;
   localparam logic [15:0] OAM_BASE     = 16'hFE00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_READ,
      ST_WRITE,
      ST_WAIT
   } dma_state_e;

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA: copies DMA_LEN bytes from {FF46 value, 00} into OAM, one byte per BYTE_PERIOD cycles.
// Optional OAM_DMA_RESTART_EN: an FF46 write during a transfer restarts it from the new source.
module oam_dma_controller
   import gb_mem_pkg::*;
#(
   parameter int BYTE_PERIOD = 4,
   parameter int DMA_LEN     = 160
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_wren,
   input  logic [7:0]  mem_data_in,
   output logic [15:0] dma_addr,
   output logic        dma_rd_en,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_data,
   output logic        oam_wren,
   output logic        dma_active,
   output logic        cpu_block,
   output logic [7:0]  reg_data_out
);

   localparam logic [3:0] START_LAST = 4'(BYTE_PERIOD - 1);
   localparam logic [3:0] WAIT_LAST  = 4'(BYTE_PERIOD - 3);
   localparam logic [7:0] LAST_BYTE  = 8'(DMA_LEN - 1);
   localparam bit         HAS_WAIT   = (BYTE_PERIOD > 2);

   dma_state_e state, state_next;
   logic [7:0] src_hi;
   logic [7:0] count;
   logic [3:0] timer;
   logic [7:0] eff_hi;
   logic       reg_write, accept, byte_end, done, in_hram;

   assign reg_write = cpu_wren && (cpu_addr == DMA_REG_ADDR);
   // E0..FF sources alias work RAM through the echo region
   assign eff_hi    = (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
   assign byte_end  = HAS_WAIT ? ((state == ST_WAIT) && (timer == WAIT_LAST))
                               : (state == ST_WRITE);
   assign done      = byte_end && (count == LAST_BYTE);

`ifdef OAM_DMA_RESTART_EN
   // the cycle a transfer finishes still rejects the write; idle accepts it next cycle
   assign accept = reg_write && !done;
`else
   assign accept = reg_write && (state == ST_IDLE);
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_START: if (timer == START_LAST) state_next = ST_READ;
         ST_READ:  state_next = ST_WRITE;
         ST_WRITE: begin
            if (HAS_WAIT) state_next = ST_WAIT;
            else          state_next = done ? ST_IDLE : ST_READ;
         end
         ST_WAIT:  if (byte_end) state_next = done ? ST_IDLE : ST_READ;
         default:  state_next = state;
      endcase
      if (accept) state_next = ST_START;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         src_hi <= 8'h00;
         count  <= 8'h00;
         timer  <= 4'h0;
      end else begin
         if (accept) begin
            src_hi <= cpu_data_in;
            count  <= 8'h00;
         end else if (byte_end && !done) begin
            count  <= count + 8'd1;
         end
         // timer measures time spent in the current state
         if (accept || (state_next != state) || (state == ST_IDLE)) timer <= 4'h0;
         else                                                      timer <= timer + 4'd1;
      end
   end

   always_comb begin
      dma_rd_en = 1'b0;
      dma_addr  = 16'h0000;
      oam_wren  = 1'b0;
      oam_addr  = 8'h00;
      oam_data  = 8'h00;
      case (state)
         ST_READ: begin
            dma_rd_en = 1'b1;
            dma_addr  = {eff_hi, count};
         end
         ST_WRITE: begin
            oam_wren = 1'b1;
            oam_addr = count;
            oam_data = mem_data_in;
         end
         default: ;
      endcase
   end

   assign dma_active   = (state != ST_IDLE);
   assign in_hram      = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);
   assign reg_data_out = src_hi;

`ifdef OAM_DMA_RESTART_EN
   assign cpu_block = dma_active && !in_hram && (cpu_addr != DMA_REG_ADDR);
`else
   assign cpu_block = dma_active && !in_hram;
`endif

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: default instance plus a BYTE_PERIOD=2 instance.
`timescale 1ns/1ps
module tb_oam_dma_controller;

`ifdef OAM_DMA_RESTART_EN
   localparam bit RESTART = 1'b1;
`else
   localparam bit RESTART = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic [15:0] cpu_addr, dma_addr;
   logic [7:0]  cpu_data_in, mem_data_in, oam_addr, oam_data, reg_data_out;
   logic        cpu_wren, dma_rd_en, oam_wren, dma_active, cpu_block;

   logic [15:0] b_cpu_addr, b_dma_addr;
   logic [7:0]  b_cpu_data_in, b_mem_data_in, b_oam_addr, b_oam_data, b_reg_data_out;
   logic        b_cpu_wren, b_dma_rd_en, b_oam_wren, b_dma_active, b_cpu_block;

   oam_dma_controller dut (
      .clock(clock), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
      .cpu_wren(cpu_wren), .mem_data_in(mem_data_in), .dma_addr(dma_addr), .dma_rd_en(dma_rd_en),
      .oam_addr(oam_addr), .oam_data(oam_data), .oam_wren(oam_wren), .dma_active(dma_active),
      .cpu_block(cpu_block), .reg_data_out(reg_data_out)
   );

   oam_dma_controller #(.BYTE_PERIOD(2), .DMA_LEN(160)) dut_b (
      .clock(clock), .reset_n(reset_n), .cpu_addr(b_cpu_addr), .cpu_data_in(b_cpu_data_in),
      .cpu_wren(b_cpu_wren), .mem_data_in(b_mem_data_in), .dma_addr(b_dma_addr), .dma_rd_en(b_dma_rd_en),
      .oam_addr(b_oam_addr), .oam_data(b_oam_data), .oam_wren(b_oam_wren), .dma_active(b_dma_active),
      .cpu_block(b_cpu_block), .reg_data_out(b_reg_data_out)
   );

   // source memory contents: page C1 holds i^5A
   function automatic logic [7:0] src_byte(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h9B;
   endfunction

   always @(posedge clock) begin
      mem_data_in   <= dma_rd_en   ? src_byte(dma_addr)   : 8'h00;
      b_mem_data_in <= b_dma_rd_en ? src_byte(b_dma_addr) : 8'h00;
   end

   int          tick = 0;
   int          wr_cnt = 0, rd_cnt = 0, b_wr_cnt = 0, b_prev = -100, b_gap_err = 0;
   logic [7:0]  oam_log [256];
   logic [7:0]  b_oam_log [256];
   logic [15:0] rd_log [1024];

   always @(posedge clock) tick <= tick + 1;

   always @(negedge clock) begin
      if (oam_wren) begin
         oam_log[oam_addr] <= oam_data;
         wr_cnt <= wr_cnt + 1;
      end
      if (dma_rd_en) begin
         rd_log[rd_cnt % 1024] <= dma_addr;
         rd_cnt <= rd_cnt + 1;
      end
      if (b_oam_wren) begin
         b_oam_log[b_oam_addr] <= b_oam_data;
         b_wr_cnt <= b_wr_cnt + 1;
         if (b_prev >= 0 && (tick - b_prev) != 2) b_gap_err <= b_gap_err + 1;
         b_prev <= tick;
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] addr;
      logic        blk_idle;
      logic        blk_active;
   } vec_t;
   vec_t tbl [8];

   task automatic write_a(input logic [7:0] d);
      @(negedge clock);
      cpu_addr = 16'hFF46; cpu_data_in = d; cpu_wren = 1'b1;
      @(negedge clock);
      cpu_wren = 1'b0; cpu_addr = 16'h0000;
   endtask

   // counts active cycles; optionally applies the cpu_block table and an FF46 write at write_at
   task automatic run_xfer(input bit use_tbl, input logic [7:0] exp_reg, input int write_at,
                           input logic [7:0] wdata, output int cyc);
      cyc = 0;
      while (dma_active && cyc < 2000) begin
         cyc++;
         if (use_tbl && cyc <= 8) begin
            cpu_addr = tbl[cyc-1].addr;
            #1;
            check("blk_active", 32'(cpu_block), 32'(tbl[cyc-1].blk_active));
            if (cyc == 1) check("reg_during_xfer", 32'(reg_data_out), 32'(exp_reg));
         end else if (cyc == write_at) begin
            cpu_addr = 16'hFF46; cpu_data_in = wdata; cpu_wren = 1'b1;
         end else begin
            cpu_addr = 16'h0000;
         end
         @(negedge clock);
      end
      cpu_wren = 1'b0; cpu_addr = 16'h0000;
   endtask

   task automatic wait_wr(input logic [7:0] a, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clock);
         if (oam_wren && oam_addr == a) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc, wr0, rd0, errs, k;
      bit ok;
      logic [15:0] exp_rd;
      logic [7:0]  exp_hi;

      cpu_addr = 0; cpu_data_in = 0; cpu_wren = 0;
      b_cpu_addr = 0; b_cpu_data_in = 0; b_cpu_wren = 0;

      tbl[0] = '{16'hC000, 1'b0, 1'b1};
      tbl[1] = '{16'hFF90, 1'b0, 1'b0};
      tbl[2] = '{16'hFF80, 1'b0, 1'b0};
      tbl[3] = '{16'hFFFE, 1'b0, 1'b0};
      tbl[4] = '{16'hFFFF, 1'b0, 1'b1};
      tbl[5] = '{16'hFF7F, 1'b0, 1'b1};
      tbl[6] = '{16'hFE00, 1'b0, 1'b1};
      tbl[7] = '{16'hFF46, 1'b0, !RESTART};

      // reset state
      repeat (3) @(negedge clock);
      check("rst_active", 32'(dma_active), 32'd0);
      check("rst_reg", 32'(reg_data_out), 32'd0);
      check("rst_rd_en", 32'(dma_rd_en), 32'd0);
      check("rst_oam_wren", 32'(oam_wren), 32'd0);
      check("rst_dma_addr", 32'(dma_addr), 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         cpu_addr = tbl[i].addr;
         #1;
         check("blk_idle", 32'(cpu_block), 32'(tbl[i].blk_idle));
      end
      cpu_addr = 16'h0000;

      // full transfer from C100
      write_a(8'hC1);
      wr0 = wr_cnt;
      run_xfer(1'b1, 8'hC1, 0, 8'h00, cyc);
      check("busy_cycles_bp4", 32'(cyc), 32'd644);
      check("oam_write_count", 32'(wr_cnt - wr0), 32'd160);
      errs = 0;
      for (int i = 0; i < 160; i++)
         if (oam_log[i] !== (8'(i) ^ 8'h5A)) errs++;
      check("oam_data_c1", 32'(errs), 32'd0);

      // echo-region source, plus a write on the final active cycle
      write_a(8'hE2);
      rd0 = rd_cnt;
      run_xfer(1'b0, 8'hE2, 644, 8'h55, cyc);
      check("busy_cycles_e2", 32'(cyc), 32'd644);
      #1;
      check("late_write_ignored", 32'(reg_data_out), 32'hE2);
      check("late_write_idle", 32'(dma_active), 32'd0);
      check("read_count_e2", 32'(rd_cnt - rd0), 32'd160);
      errs = 0;
      for (int i = 0; i < 160; i++)
         if (rd_log[(rd0 + i) % 1024] !== {8'hC2, 8'(i)}) errs++;
      check("dma_addr_seq_e2", 32'(errs), 32'd0);

      write_a(8'h55);
      check("idle_write_accepted", 32'(reg_data_out), 32'h55);
      check("idle_write_active", 32'(dma_active), 32'd1);

      // reset in the middle of byte 50
      wait_wr(8'd50, ok);
      check("reached_byte50", 32'(ok), 32'd1);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("abort_active", 32'(dma_active), 32'd0);
      check("abort_reg", 32'(reg_data_out), 32'd0);
      check("abort_oam_wren", 32'(oam_wren), 32'd0);
      check("abort_rd_en", 32'(dma_rd_en), 32'd0);
      wr0 = wr_cnt;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (20) @(negedge clock);
      check("no_writes_after_abort", 32'(wr_cnt - wr0), 32'd0);
      check("idle_after_abort", 32'(dma_active), 32'd0);

      // second FF46 write while byte 80 is in flight
      write_a(8'hC1);
      wait_wr(8'd80, ok);
      check("reached_byte80", 32'(ok), 32'd1);
      @(negedge clock);
      cpu_addr = 16'hFF46; cpu_data_in = 8'hD0; cpu_wren = 1'b1;
      @(negedge clock);
      cpu_wren = 1'b0; cpu_addr = 16'h0000;
      k = 0;
      while (!dma_rd_en && k < 100) begin
         k++;
         @(negedge clock);
      end
      exp_rd = RESTART ? 16'hD000 : 16'hC151;
      exp_hi = RESTART ? 8'hD0 : 8'hC1;
      check("restart_next_addr", 32'(dma_addr), 32'(exp_rd));
      k = 0;
      while (dma_active && k < 2000) begin
         k++;
         @(negedge clock);
      end
      check("restart_done", 32'(dma_active), 32'd0);
      check("restart_reg", 32'(reg_data_out), 32'(exp_hi));
      check("restart_oam0", 32'(oam_log[0]), 32'(src_byte({exp_hi, 8'h00})));
      check("restart_oam159", 32'(oam_log[159]), 32'(src_byte({exp_hi, 8'h9F})));

      // BYTE_PERIOD=2 instance
      @(negedge clock);
      b_cpu_addr = 16'hFF46; b_cpu_data_in = 8'hC1; b_cpu_wren = 1'b1;
      @(negedge clock);
      b_cpu_wren = 1'b0; b_cpu_addr = 16'h0000;
      cyc = 0;
      while (b_dma_active && cyc < 2000) begin
         cyc++;
         @(negedge clock);
      end
      check("busy_cycles_bp2", 32'(cyc), 32'd322);
      check("bp2_write_count", 32'(b_wr_cnt), 32'd160);
      check("bp2_write_spacing", 32'(b_gap_err), 32'd0);
      errs = 0;
      for (int i = 0; i < 160; i++)
         if (b_oam_log[i] !== (8'(i) ^ 8'h5A)) errs++;
      check("bp2_oam_data", 32'(errs), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
